uart_fifo_unit: RTL and testbench

Buffered, parametrised successor to the core's UART unit: an 8N1 transmitter and receiver, each decoupled from the multicycle controller by a synchronous FIFO of configurable depth. The controller issues `go` with `rors` selecting receive or send and waits for `done`, as with the current unit. Receive no longer stalls when a byte is waiting, and a send only stalls when the TX FIFO is full. The unit sits beside the datapath in the core top level and drives the board pins `txd` and `rxd`.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_fifo_unit.sv | 209 ++++++++++++++++++++
 tb/tb_uart_fifo_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the buffered 8N1 UART unit.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_RX, WAIT_TX, DONE} req_state_t;
    typedef enum logic {T_IDLE, T_SHIFT} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with an extra pointer wrap bit; read data is taken
// combinationally from the head entry.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = CW'(wptr - rptr);

endmodule

// File: rtl/uart_fifo_unit.sv
// Buffered 8N1 UART: controller request FSM in front of RX/TX FIFOs feeding
// independent serial engines.
module uart_fifo_unit
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DEPTH            = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic                         rors,
    input  logic [7:0]                   txdata,
    output logic                         done,
    output logic [7:0]                   rxdata,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic                         overrun,
    output logic                         frame_err,
    input  logic                         clr_err,
    output logic                         txd,
    input  logic                         rxd
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W   = $clog2(BIT_CYC);

    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_rdata, tx_rdata, tx_latched, rx_shreg;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shreg),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(tx_latched),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // ---------------- controller request FSM ----------------
    req_state_t req_state, req_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_next = req_state;
        rx_pop   = 1'b0;
        tx_push  = 1'b0;
        done     = 1'b0;
        case (req_state)
            IDLE:    if (go) req_next = rors ? WAIT_TX : WAIT_RX;
            WAIT_RX: if (!rx_empty) begin
                         rx_pop   = 1'b1;
                         req_next = DONE;
                     end
            WAIT_TX: if (!tx_full) begin
                         tx_push  = 1'b1;
                         req_next = DONE;
                     end
            DONE:    begin
                         done     = 1'b1;
                         req_next = IDLE;
                     end
            default: req_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) req_state <= IDLE;
        else     req_state <= req_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxdata     <= '0;
            tx_latched <= '0;
        end else begin
            if (req_state == IDLE && go) tx_latched <= txdata;
            if (rx_pop)                  rxdata     <= rx_rdata;
        end
    end

    // ---------------- TX engine ----------------
    tx_state_t             tx_state, tx_next;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic [CNT_W-1:0]      tx_cnt;
    logic [3:0]            tx_bits;
    logic                  tx_bit_end, tx_last;

    assign tx_bit_end = (tx_cnt == CNT_W'(BIT_CYC - 1));
    assign tx_last    = (tx_bits == 4'(FRAME_BITS - 1));

    // The next frame is loaded straight out of the stop bit, so back-to-back bytes have no gap.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            T_IDLE:  if (!tx_empty) begin
                         tx_pop  = 1'b1;
                         tx_next = T_SHIFT;
                     end
            T_SHIFT: if (tx_bit_end && tx_last) begin
                         tx_pop  = !tx_empty;
                         tx_next = tx_empty ? T_IDLE : T_SHIFT;
                     end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) tx_state <= T_IDLE;
        else     tx_state <= tx_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shreg <= '1;
            tx_cnt   <= '0;
            tx_bits  <= '0;
        end else if (tx_pop) begin
            tx_shreg <= {STOP_BIT, tx_rdata, START_BIT};
            tx_cnt   <= '0;
            tx_bits  <= '0;
        end else if (tx_state == T_SHIFT) begin
            if (tx_bit_end) begin
                tx_shreg <= {STOP_BIT, tx_shreg[FRAME_BITS-1:1]};
                tx_cnt   <= '0;
                tx_bits  <= tx_bits + 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign txd = tx_shreg[0];

    // ---------------- RX engine ----------------
    rx_state_t        rx_state, rx_next;
    logic [1:0]       rx_sync;
    logic             rx_s, rx_tick, ovr_set, ferr_set;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_state == R_START) ? (rx_cnt == CNT_W'(CLK_PER_HALF_BIT - 1))
                                           : (rx_cnt == CNT_W'(BIT_CYC - 1));

    always_comb begin
        rx_next  = rx_state;
        rx_push  = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        case (rx_state)
            R_IDLE:   if (!rx_s) rx_next = R_START;
            R_START:  if (rx_tick) rx_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:   if (rx_tick && rx_bits == 3'd7) rx_next = R_STOP;
            R_STOP:   if (rx_tick) begin
                          if (rx_s) begin
                              rx_push = !rx_full;
                              ovr_set = rx_full;
                              rx_next = R_IDLE;
                          end else begin
                              ferr_set = 1'b1;
                              rx_next  = R_WAITHI;
                          end
                      end
            R_WAITHI: if (rx_s) rx_next = R_IDLE;
            default:  rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shreg <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            if (rx_state == R_IDLE || rx_state == R_WAITHI || rx_tick) rx_cnt <= '0;
            else                                                       rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == R_START && rx_tick) rx_bits <= '0;
            if (rx_state == R_DATA && rx_tick) begin
                rx_shreg <= {rx_s, rx_shreg[7:1]};
                rx_bits  <= rx_bits + 1'b1;
            end
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Randomised self-checking bench for uart_fifo_unit against a queue-based
// model of the serial line and both FIFOs.
module tb_uart_fifo_unit;

    localparam int CPH   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * CPH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, go, rors, clr_err, rxd;
    logic [7:0]    txdata, rxdata;
    logic          done, overrun, frame_err, txd;
    logic [CW-1:0] rx_count, tx_count;

    uart_fifo_unit #(.CLK_PER_HALF_BIT(CPH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .go(go), .rors(rors), .txdata(txdata),
        .done(done), .rxdata(rxdata), .rx_count(rx_count), .tx_count(tx_count),
        .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_tx[$];
    int tx_seen[$];
    int rx_model[$];
    bit ovr_model  = 1'b0;
    bit ferr_model = 1'b0;
    bit mon_en     = 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line monitor: decodes each frame on txd at mid-bit; bad framing is recorded as -1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && txd == 1'b0) begin : decode
                int v;
                bit ok;
                v  = 0;
                ok = 1'b1;
                wait_cyc(BIT / 2);
                if (txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(BIT);
                    v[i] = txd;
                end
                wait_cyc(BIT);
                if (txd !== 1'b1) ok = 1'b0;
                if (mon_en) tx_seen.push_back(ok ? v : -1);
            end
        end
    end

    task automatic drive_frame(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(BIT);
        end
        rxd = stop;
        wait_cyc(BIT);
        rxd = 1'b1;
        wait_cyc(4);
        if (stop) begin
            if (rx_model.size() < DEPTH) rx_model.push_back(int'(b));
            else                         ovr_model = 1'b1;
        end else begin
            ferr_model = 1'b1;
        end
    endtask

    task automatic do_req(input bit r, input logic [7:0] d, output int lat, output int rdat);
        go     = 1'b1;
        rors   = r;
        txdata = d;
        wait_cyc(1);
        go  = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            wait_cyc(1);
            lat++;
        end
        check("done_seen", int'(done), 1);
        rdat = int'(rxdata);
        wait_cyc(1);
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic send(input logic [7:0] d, output int lat);
        int rd;
        do_req(1'b1, d, lat, rd);
        exp_tx.push_back(int'(d));
    endtask

    task automatic receive(input string tag);
        int lat, rd, want;
        want = rx_model.pop_front();
        do_req(1'b0, 8'h00, lat, rd);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_data"}, rd, want);
    endtask

    task automatic drain_tx(input string tag);
        int n = 0;
        while (tx_seen.size() < exp_tx.size() && n < 5000) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(4);
        check({tag, "_frames"}, tx_seen.size(), exp_tx.size());
        while (tx_seen.size() > 0 && exp_tx.size() > 0)
            check({tag, "_byte"}, tx_seen.pop_front(), exp_tx.pop_front());
        tx_seen.delete();
        exp_tx.delete();
    endtask

    initial begin
        int lat, viol;
        logic [7:0] b;

        rst = 1'b1; go = 1'b0; rors = 1'b0; txdata = '0; clr_err = 1'b0; rxd = 1'b1;
        wait_cyc(3);
        check("rst_txd", int'(txd), 1);
        check("rst_done", int'(done), 0);
        check("rst_rx_count", int'(rx_count), 0);
        check("rst_tx_count", int'(tx_count), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_rxdata", int'(rxdata), 0);
        rst = 1'b0;
        wait_cyc(2);

        // Single send of 0xA5
        send(8'hA5, lat);
        check("send_a5_lat", lat, 2);
        drain_tx("send_a5");

        // Six sends into a DEPTH=4 TX path: the sixth stalls until the shifter frees up
        for (int k = 1; k <= 6; k++) begin
            b = 8'($urandom);
            send(b, lat);
            if (k <= 5) check("burst_lat", lat, 2);
            else        check("burst6_stalled", int'(lat > 2), 1);
            if (k == 5) check("burst_tx_count", int'(tx_count), DEPTH);
        end
        drain_tx("burst");

        // Two received frames then two pops
        drive_frame(8'h3C, 1'b1);
        drive_frame(8'h81, 1'b1);
        check("rx2_count", int'(rx_count), rx_model.size());
        receive("rx2_a");
        check("rx2_count_a", int'(rx_count), rx_model.size());
        receive("rx2_b");
        check("rx2_count_b", int'(rx_count), rx_model.size());

        // Overrun: DEPTH+1 frames with no pops
        for (int k = 0; k < DEPTH + 1; k++) drive_frame(8'($urandom), 1'b1);
        check("ovr_count", int'(rx_count), rx_model.size());
        check("ovr_flag", int'(overrun), int'(ovr_model));
        for (int k = 0; k < DEPTH; k++) receive("ovr_pop");
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err   = 1'b0;
        ovr_model = 1'b0;
        check("ovr_cleared", int'(overrun), int'(ovr_model));

        // Framing error then a good 0x55
        drive_frame(8'($urandom), 1'b0);
        check("ferr_no_push", int'(rx_count), rx_model.size());
        check("ferr_flag", int'(frame_err), int'(ferr_model));
        drive_frame(8'h55, 1'b1);
        check("ferr_sticky", int'(frame_err), int'(ferr_model));
        receive("after_ferr");
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err    = 1'b0;
        ferr_model = 1'b0;
        check("ferr_cleared", int'(frame_err), int'(ferr_model));

        // Mixed random traffic
        for (int k = 0; k < 4; k++) begin
            drive_frame(8'($urandom), 1'b1);
            receive("mix_rx");
            send(8'($urandom), lat);
            check("mix_tx_lat", lat, 2);
        end
        drain_tx("mix");

        // Reset in the middle of a TX frame
        drive_frame(8'($urandom), 1'b1);
        check("prerst_rx_count", int'(rx_count), rx_model.size());
        send(8'($urandom), lat);
        send(8'($urandom), lat);
        wait_cyc(30);
        mon_en = 1'b0;
        rst    = 1'b1;
        wait_cyc(1);
        check("midrst_txd", int'(txd), 1);
        check("midrst_tx_count", int'(tx_count), 0);
        check("midrst_rx_count", int'(rx_count), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_rxdata", int'(rxdata), 0);
        rst  = 1'b0;
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            wait_cyc(1);
            if (txd !== 1'b1 || done !== 1'b0) viol++;
        end
        check("postrst_quiet", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
